perceptron_sample_loader: RTL and testbench
===========================================

// Module: perceptron_sample_loader
// PURPOSE
// - Writer side of the perceptron's training-data interface: takes a byte stream of samples + labels,
//   buffers one full training set, then replays it to the trainer for a set number of epochs.
// - Sits between the pin-level byte input and the perceptron trainer; replaces hard-coded X/Y tables.
// PARAMETERS
// - N_SAMPLES  3  samples per training set
// - DIM        2  features per sample
// - DATA_W     8  bits per feature (unsigned)
// - EPOCH_W    4  width of epoch count
// PORTS
// - clk          in   1                 single clock; all logic on posedge
// - rst          in   1                 synchronous reset, active-high
// - in_valid     in   1                 load byte valid
// - in_byte      in   8                 load byte: feature, or label in bit0
// - in_ready     out  1                 loader accepts in_byte this cycle
// - reload       in   1                 READY only: discard set, return to LOAD
// - start        in   1                 READY only: begin streaming
// - num_epochs   in   EPOCH_W           epochs to stream, sampled at start
// - smp_valid    out  1                 sample valid to trainer
// - smp_ready    in   1                 trainer accepts sample
// - smp_x        out  DIM*DATA_W        features; feature d at [d*DATA_W +: DATA_W]
// - smp_y        out  1                 label
// - smp_idx      out  clog2(N_SAMPLES)  sample index
// - smp_last     out  1                 last sample of current epoch
// - epoch_done   out  1                 1-cycle pulse after last handshake of an epoch
// - load_done    out  1                 full set buffered (READY or STREAM)
// - busy         out  1                 STREAM active
// - err_overflow out  1                 sticky: in_valid seen while in_ready low
// BEHAVIOUR
// - Reset: state=LOAD, all counters 0; in_ready=1; smp_valid, smp_y, smp_last, epoch_done, load_done,
//   busy, err_overflow=0; smp_x, smp_idx=0. Buffer contents not cleared (don't-care).
// - States: LOAD -> READY -> STREAM -> READY; READY --reload--> LOAD. rst from any state -> LOAD.
// - LOAD: in_ready=1. Byte order per sample s=0..N-1: x[s][0..DIM-1] then label byte (bit0 kept, rest
//   ignored). Byte stored on in_valid&in_ready. After byte N*(DIM+1) -> READY, load_done=1 next cycle.
// - READY: in_ready=0. start with num_epochs!=0 -> STREAM; start with num_epochs==0 ignored.
//   start and reload same cycle: reload wins. in_valid while in_ready=0 sets err_overflow (cleared only by rst).
// - STREAM: smp_valid=1 from cycle after start accepted; outputs registered, held stable while
//   smp_valid&!smp_ready. On handshake next sample presented next cycle, no bubble (1 sample/cycle max).
// - After handshake with smp_last=1: epoch_done pulses next cycle; epoch count++; if count==num_epochs,
//   smp_valid drops that same cycle and state -> READY (buffer retained, may restart); else wrap idx.
// - start/reload/in_valid during STREAM ignored (in_valid still flags err_overflow).
// - rst mid-stream: stream aborts immediately, load_done=0, next set must be fully reloaded.
// CONFIGURATION
// - ROTATE_ORDER_EN defined: epoch e begins at sample idx (e mod N_SAMPLES), wraps, ends one before;
//   smp_last marks the N-th sample of the epoch, smp_idx reports the true stored index.
// - Not defined: every epoch streams idx 0..N_SAMPLES-1 in order.
// TESTING
// - Load 2,3,0,4,5,1,1,2,1; start num_epochs=2, smp_ready=1 -> 6 beats x=(2,3)y0,(4,5)y1,(1,2)y1 x2,
//   smp_last on idx 2, epoch_done pulses twice, then busy=0, load_done=1.
// - Same set, smp_ready toggles 1/0 -> each sample held stable while stalled, order and count unchanged.
// - Extra byte after 9th (state READY) -> not accepted, err_overflow=1 and stays 1 through restart.
// - rst asserted on 2nd beat of epoch 1 -> next cycle smp_valid=0, load_done=0, in_ready=1.
// - start with num_epochs=0 -> no smp_valid; reload then 9 new bytes -> new values streamed.
// - ROTATE_ORDER_EN, num_epochs=3 -> idx order 0,1,2 | 1,2,0 | 2,0,1; smp_last on 3rd beat of each.

Source files
------------

// File: rtl/perceptron_sample_loader.sv
// perceptron_sample_loader
//
// Writer side of the perceptron training-data path. A byte stream loads one full training set
// (per sample: DIM feature bytes, then a label byte whose bit0 is the label). The set is then
// replayed to the trainer over a valid/ready interface for num_epochs epochs, and can be
// replayed again or discarded with reload.
//
// Optional feature: define ROTATE_ORDER_EN to make epoch e start at stored sample
// (e mod N_SAMPLES) and wrap; smp_idx always reports the true stored index.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   in_valid/in_byte/in_ready   byte load interface (ready only while loading)
//   reload        READY only: discard the buffered set and return to loading
//   start         READY only: begin streaming num_epochs epochs (0 is ignored)
//   num_epochs    epoch count, sampled when start is accepted
//   smp_valid/smp_ready         sample handshake to the trainer
//   smp_x/smp_y/smp_idx/smp_last  registered sample payload
//   epoch_done    one-cycle pulse after the last handshake of each epoch
//   load_done     a full set is buffered
//   busy          streaming in progress
//   err_overflow  sticky: a byte was offered while in_ready was low
module perceptron_sample_loader #(
  parameter int unsigned N_SAMPLES = 3,
  parameter int unsigned DIM       = 2,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned EPOCH_W   = 4,
  localparam int unsigned IDX_W    = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [7:0]              in_byte,
  output logic                    in_ready,
  input  logic                    reload,
  input  logic                    start,
  input  logic [EPOCH_W-1:0]      num_epochs,
  output logic                    smp_valid,
  input  logic                    smp_ready,
  output logic [DIM*DATA_W-1:0]   smp_x,
  output logic                    smp_y,
  output logic [IDX_W-1:0]        smp_idx,
  output logic                    smp_last,
  output logic                    epoch_done,
  output logic                    load_done,
  output logic                    busy,
  output logic                    err_overflow
);

  localparam int unsigned POS_W = $clog2(DIM + 1);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_SAMPLES - 1);
  localparam logic [POS_W-1:0] LblPos  = POS_W'(DIM);

  typedef enum logic [1:0] {StLoad, StReady, StStream} state_e;

  state_e state_q, state_d;

  // Sample buffer, intentionally not reset.
  logic [DIM*DATA_W-1:0] feat_q [N_SAMPLES];
  logic [DIM*DATA_W-1:0] feat_d [N_SAMPLES];
  logic [N_SAMPLES-1:0]  lbl_q, lbl_d;

  logic [IDX_W-1:0]   ld_smp_q, ld_smp_d;
  logic [POS_W-1:0]   ld_pos_q, ld_pos_d;
  logic [IDX_W-1:0]   beat_q, beat_d;
  logic [EPOCH_W-1:0] ep_cnt_q, ep_cnt_d;
  logic [EPOCH_W-1:0] num_q, num_d;

  logic                  smp_valid_q, smp_valid_d;
  logic [DIM*DATA_W-1:0] smp_x_q, smp_x_d;
  logic                  smp_y_q, smp_y_d;
  logic [IDX_W-1:0]      smp_idx_q, smp_idx_d;
  logic                  smp_last_q, smp_last_d;
  logic                  epoch_done_q, epoch_done_d;
  logic                  load_done_q, load_done_d;
  logic                  err_q, err_d;

  logic               present;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   next_start;
  logic [EPOCH_W-1:0] ep_cnt_nxt;

  assign in_ready = (state_q == StLoad);

  always_comb begin
    state_d      = state_q;
    feat_d       = feat_q;
    lbl_d        = lbl_q;
    ld_smp_d     = ld_smp_q;
    ld_pos_d     = ld_pos_q;
    beat_d       = beat_q;
    ep_cnt_d     = ep_cnt_q;
    num_d        = num_q;
    smp_valid_d  = smp_valid_q;
    smp_x_d      = smp_x_q;
    smp_y_d      = smp_y_q;
    smp_idx_d    = smp_idx_q;
    smp_last_d   = smp_last_q;
    epoch_done_d = 1'b0;
    load_done_d  = load_done_q;
    err_d        = err_q | (in_valid & ~in_ready);
    present      = 1'b0;
    sel_idx      = smp_idx_q;
    ep_cnt_nxt   = ep_cnt_q + EPOCH_W'(1);
`ifdef ROTATE_ORDER_EN
    next_start   = IDX_W'(32'(ep_cnt_nxt) % N_SAMPLES);
`else
    next_start   = '0;
`endif

    unique case (state_q)
      StLoad: begin
        if (in_valid) begin
          if (ld_pos_q == LblPos) begin
            lbl_d[ld_smp_q] = in_byte[0];
            ld_pos_d        = '0;
            if (ld_smp_q == LastIdx) begin
              ld_smp_d    = '0;
              state_d     = StReady;
              load_done_d = 1'b1;
            end else begin
              ld_smp_d = ld_smp_q + IDX_W'(1);
            end
          end else begin
            feat_d[ld_smp_q][ld_pos_q*DATA_W +: DATA_W] = DATA_W'(in_byte);
            ld_pos_d = ld_pos_q + POS_W'(1);
          end
        end
      end
      StReady: begin
        if (reload) begin
          state_d     = StLoad;
          load_done_d = 1'b0;
          ld_smp_d    = '0;
          ld_pos_d    = '0;
        end else if (start && (num_epochs != '0)) begin
          state_d  = StStream;
          num_d    = num_epochs;
          ep_cnt_d = '0;
          beat_d   = '0;
          sel_idx  = '0;
          present  = 1'b1;
        end
      end
      StStream: begin
        if (smp_valid_q && smp_ready) begin
          if (smp_last_q) begin
            epoch_done_d = 1'b1;
            ep_cnt_d     = ep_cnt_nxt;
            if (ep_cnt_nxt == num_q) begin
              smp_valid_d = 1'b0;
              state_d     = StReady;
            end else begin
              beat_d  = '0;
              sel_idx = next_start;
              present = 1'b1;
            end
          end else begin
            beat_d  = beat_q + IDX_W'(1);
            sel_idx = (smp_idx_q == LastIdx) ? '0 : smp_idx_q + IDX_W'(1);
            present = 1'b1;
          end
        end
      end
      default: state_d = StLoad;
    endcase

    if (present) begin
      smp_valid_d = 1'b1;
      smp_idx_d   = sel_idx;
      smp_x_d     = feat_q[sel_idx];
      smp_y_d     = lbl_q[sel_idx];
      smp_last_d  = (beat_d == LastIdx);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StLoad;
      ld_smp_q     <= '0;
      ld_pos_q     <= '0;
      beat_q       <= '0;
      ep_cnt_q     <= '0;
      num_q        <= '0;
      smp_valid_q  <= 1'b0;
      smp_x_q      <= '0;
      smp_y_q      <= 1'b0;
      smp_idx_q    <= '0;
      smp_last_q   <= 1'b0;
      epoch_done_q <= 1'b0;
      load_done_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ld_smp_q     <= ld_smp_d;
      ld_pos_q     <= ld_pos_d;
      beat_q       <= beat_d;
      ep_cnt_q     <= ep_cnt_d;
      num_q        <= num_d;
      smp_valid_q  <= smp_valid_d;
      smp_x_q      <= smp_x_d;
      smp_y_q      <= smp_y_d;
      smp_idx_q    <= smp_idx_d;
      smp_last_q   <= smp_last_d;
      epoch_done_q <= epoch_done_d;
      load_done_q  <= load_done_d;
      err_q        <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    feat_q <= feat_d;
    lbl_q  <= lbl_d;
  end

  assign smp_valid    = smp_valid_q;
  assign smp_x        = smp_x_q;
  assign smp_y        = smp_y_q;
  assign smp_idx      = smp_idx_q;
  assign smp_last     = smp_last_q;
  assign epoch_done   = epoch_done_q;
  assign load_done    = load_done_q;
  assign busy         = (state_q == StStream);
  assign err_overflow = err_q;

endmodule

// File: tb/tb_perceptron_sample_loader.sv
// Scoreboard bench for perceptron_sample_loader: stimulus pushes expected samples computed from
// the loaded bytes; a negedge monitor pops and compares on every handshake and checks that a
// stalled sample holds still.
module tb_perceptron_sample_loader;
  localparam int N  = 3;
  localparam int EW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = '0;
  logic        in_ready;
  logic        reload = 1'b0;
  logic        start = 1'b0;
  logic [EW-1:0] num_epochs = '0;
  logic        smp_valid;
  logic        smp_ready = 1'b1;
  logic [15:0] smp_x;
  logic        smp_y;
  logic [1:0]  smp_idx;
  logic        smp_last;
  logic        epoch_done;
  logic        load_done;
  logic        busy;
  logic        err_overflow;

  perceptron_sample_loader dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_byte      (in_byte),
    .in_ready     (in_ready),
    .reload       (reload),
    .start        (start),
    .num_epochs   (num_epochs),
    .smp_valid    (smp_valid),
    .smp_ready    (smp_ready),
    .smp_x        (smp_x),
    .smp_y        (smp_y),
    .smp_idx      (smp_idx),
    .smp_last     (smp_last),
    .epoch_done   (epoch_done),
    .load_done    (load_done),
    .busy         (busy),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] x;
    logic        y;
    logic [1:0]  idx;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  logic [15:0] mdl_x [N];
  logic        mdl_y [N];
  int vecs = 0;
  int errs = 0;
  int hs_cnt = 0;
  int ed_cnt = 0;
  int ready_mode = 0;  // 0: always ready, 1: toggle, 2: random

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // smp_ready driver
  initial begin
    bit tog = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tog = ~tog;
      case (ready_mode)
        0:       smp_ready = 1'b1;
        1:       smp_ready = tog;
        default: smp_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: handshake scoreboard, stall stability, epoch_done counting
  initial begin
    bit    stalled = 1'b0;
    beat_t held;
    beat_t cur;
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        cur = '{x: smp_x, y: smp_y, idx: smp_idx, last: smp_last};
        if (epoch_done) ed_cnt++;
        if (stalled) begin
          check("stall_valid", 32'(smp_valid), 32'd1);
          check("stall_hold", 32'(cur), 32'(held));
        end
        if (smp_valid && smp_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 32'(cur), 32'h0);
            check("unexpected_beat_cnt", 32'(hs_cnt), 32'(0));
          end else begin
            e = exp_q.pop_front();
            check("beat_x", 32'(cur.x), 32'(e.x));
            check("beat_y", 32'(cur.y), 32'(e.y));
            check("beat_idx", 32'(cur.idx), 32'(e.idx));
            check("beat_last", 32'(cur.last), 32'(e.last));
          end
        end
        stalled = smp_valid && !smp_ready;
        held    = cur;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    start = 1'b0;
    reload = 1'b0;
    tick();
    tick();
    exp_q.delete();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_smp_valid", 32'(smp_valid), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_overflow), 32'd0);
    check("rst_idx_x", {14'(smp_x), smp_idx, smp_y, smp_last, epoch_done}, 32'd0);
    rst = 1'b0;
  endtask

  task automatic load_set(input logic [7:0] b [9]);
    for (int i = 0; i < 9; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      in_byte  = b[i];
      tick();
    end
    in_valid = 1'b0;
    for (int s = 0; s < N; s++) begin
      mdl_x[s] = {b[s*3+1], b[s*3]};
      mdl_y[s] = b[s*3+2][0];
    end
    check("load_done", 32'(load_done), 32'd1);
    check("load_in_ready", 32'(in_ready), 32'd0);
  endtask

  task automatic random_set(output logic [7:0] b [9]);
    for (int i = 0; i < 9; i++) b[i] = 8'($urandom);
  endtask

  task automatic push_expected(input int n);
    int idx;
    for (int e = 0; e < n; e++) begin
      for (int k = 0; k < N; k++) begin
`ifdef ROTATE_ORDER_EN
        idx = (e + k) % N;
`else
        idx = k;
`endif
        exp_q.push_back('{x: mdl_x[idx], y: mdl_y[idx], idx: 2'(idx), last: (k == N - 1)});
      end
    end
  endtask

  task automatic run_stream(input int n, input int mode);
    bit done = 1'b0;
    ready_mode = mode;
    push_expected(n);
    ed_cnt = 0;
    hs_cnt = 0;
    num_epochs = EW'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    num_epochs = EW'($urandom);
    check("stream_busy", 32'(busy), 32'd1);
    for (int c = 0; c < 400 && !done; c++) begin
      if (!busy) done = 1'b1;
      else tick();
    end
    check("stream_finished", 32'(done), 32'd1);
    tick();
    check("epoch_done_cnt", 32'(ed_cnt), 32'(n));
    check("beats_left", 32'(exp_q.size()), 32'd0);
    check("end_valid", 32'(smp_valid), 32'd0);
    check("end_load_done", 32'(load_done), 32'd1);
    check("end_busy", 32'(busy), 32'd0);
    check("end_epoch_done", 32'(epoch_done), 32'd0);
    exp_q.delete();
    ready_mode = 0;
  endtask

  initial begin
    logic [7:0] b [9];
    bit ok;

    do_reset();

    b = '{8'd2, 8'd3, 8'd0, 8'd4, 8'd5, 8'd1, 8'd1, 8'd2, 8'd1};
    load_set(b);
    run_stream(2, 0);
    run_stream(2, 1);

    // Extra byte while READY: refused, flagged, buffer unchanged.
    in_valid = 1'b1;
    in_byte  = 8'hff;
    tick();
    in_valid = 1'b0;
    check("overflow_set", 32'(err_overflow), 32'd1);
    run_stream(3, 2);
    check("overflow_sticky", 32'(err_overflow), 32'd1);

    // Reset on the 2nd beat of epoch 1.
    push_expected(2);
    hs_cnt = 0;
    num_epochs = 4'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      if (hs_cnt >= 4) ok = 1'b1;
      else tick();
    end
    check("mid_reach", 32'(ok), 32'd1);
    check("mid_valid_before", 32'(smp_valid), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 32'(smp_valid), 32'd0);
    check("mid_rst_load_done", 32'(load_done), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_err", 32'(err_overflow), 32'd0);
    rst = 1'b0;
    exp_q.delete();

    // start with zero epochs is ignored; reload beats a simultaneous start.
    random_set(b);
    load_set(b);
    num_epochs = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    check("zero_ep_busy", 32'(busy), 32'd0);
    check("zero_ep_valid", 32'(smp_valid), 32'd0);
    num_epochs = 4'd3;
    start  = 1'b1;
    reload = 1'b1;
    tick();
    start  = 1'b0;
    reload = 1'b0;
    check("reload_in_ready", 32'(in_ready), 32'd1);
    check("reload_load_done", 32'(load_done), 32'd0);
    check("reload_busy", 32'(busy), 32'd0);

    random_set(b);
    load_set(b);
    run_stream(int'($urandom_range(1, 4)), 2);

    for (int it = 0; it < 4; it++) begin
      reload = 1'b1;
      tick();
      reload = 1'b0;
      random_set(b);
      load_set(b);
      run_stream(int'($urandom_range(1, 5)), int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
